// File: rtl/fx_chain_switcher.sv
// fx_chain_switcher
//   NUM_SLOTS effect slots in series. Each slot is switched in/out with a
//   per-sample linear crossfade between its dry send and its wet return, so
//   bypass changes never click. Slot enables come from debounced foot buttons
//   (via the BUTTON_MAP CSR) or from direct CSR writes to ENABLE.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   sample_tick_i             one-cycle pulse per audio sample
//   button_i                  raw asynchronous foot buttons, active high
//   csr_*                     Avalon-MM slave: 0 ENABLE, 1 BUTTON_MAP, 2 STATUS
//                             Handshake: no wait states; a read strobe in cycle
//                             t yields csr_readdatavalid_o/csr_readdata_o in t+1.
//   data_i / data_o           chain input / chain output samples
//   send_o / return_i         per-slot dry send to and wet return from effects
//   slot_active_o             target enable per slot
//   slot_fading_o             slot gain strictly between 0 and FADE_STEPS
module fx_chain_switcher #(
  parameter int          DATA_WIDTH      = 16,
  parameter int          NUM_SLOTS       = 4,
  parameter int          NUM_BUTTONS     = 3,
  parameter int          DEBOUNCE_CYCLES = 65536,
  parameter int          FADE_STEPS      = 64,
  parameter logic [31:0] DEFAULT_MAP     = 32'h0000_0401
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            sample_tick_i,
  input  logic [NUM_BUTTONS-1:0]          button_i,
  input  logic [1:0]                      csr_address_i,
  input  logic                            csr_write_i,
  input  logic                            csr_read_i,
  input  logic [31:0]                     csr_writedata_i,
  output logic [31:0]                     csr_readdata_o,
  output logic                            csr_readdatavalid_o,
  output logic                            csr_waitrequest_o,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic [NUM_SLOTS*DATA_WIDTH-1:0] send_o,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] return_i,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [NUM_SLOTS-1:0]            slot_active_o,
  output logic [NUM_SLOTS-1:0]            slot_fading_o
);

  localparam int FW = $clog2(FADE_STEPS);
  localparam int GW = FW + 1;
  localparam int PW = DATA_WIDTH + FW + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] G_MAX    = GW'(FADE_STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_OFF      = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_ON       = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  logic [NUM_BUTTONS-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0]    deb_q, deb_d, press_q, press_d;
  logic [NUM_BUTTONS*CW-1:0] cnt_q, cnt_d;
  logic [31:0]               map_q, map_d;
  logic [NUM_SLOTS-1:0]      enable_q, enable_d, toggle;
  logic [NUM_SLOTS*GW-1:0]   gain_q, gain_d;
  logic [NUM_SLOTS*2-1:0]    state_q, state_d;
  logic [NUM_SLOTS-1:0]      fading;
  logic [NUM_SLOTS*DATA_WIDTH-1:0] y_q, y_d;
  logic [31:0]               rdata_q, rdata_d, status;
  logic                      rvalid_q, rvalid_d;

  // Button path: two-flop synchroniser, then a counter that must see the new
  // level for DEBOUNCE_CYCLES consecutive cycles. Returning to the accepted
  // level clears the counter, so any bounce restarts the wait.
  assign sync1_d = button_i;
  assign sync2_d = sync1_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b*CW +: CW] == CNT_LAST) deb_d[b] = sync2_q[b];
        else cnt_d[b*CW +: CW] = cnt_q[b*CW +: CW] + 1'b1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  // Enable register: a CSR write to ENABLE wins and swallows any toggle.
  always_comb begin
    toggle = '0;
    for (int b = 0; b < NUM_BUTTONS; b++)
      if (press_q[b]) toggle = toggle | map_q[8*b +: NUM_SLOTS];
    if (csr_write_i && csr_address_i == 2'd0) enable_d = csr_writedata_i[NUM_SLOTS-1:0];
    else enable_d = enable_q ^ toggle;
    map_d = (csr_write_i && csr_address_i == 2'd1) ? csr_writedata_i : map_q;
  end

  // CSR read path, registered.
  always_comb begin
    status = '0;
    status[NUM_SLOTS-1:0]   = enable_q;
    status[8 +: NUM_SLOTS]  = fading;
    rdata_d  = '0;
    rvalid_d = csr_read_i;
    if (csr_read_i) begin
      case (csr_address_i)
        2'd0:    rdata_d[NUM_SLOTS-1:0] = enable_q;
        2'd1:    rdata_d = map_q;
        2'd2:    rdata_d = status;
        default: rdata_d = '0;
      endcase
    end
  end

  // Per-slot gain FSM. The gain walks one step per sample tick toward the
  // target (F when enabled, 0 when not); a reversal mid-fade just changes
  // direction from the current gain.
  always_comb begin
    logic [GW-1:0] g_cur, g_nxt;
    logic          en;
    gain_d = gain_q;
    state_d = state_q;
    fading = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      en    = enable_q[k];
      g_cur = gain_q[k*GW +: GW];
      g_nxt = g_cur;
      fading[k] = (state_q[2*k +: 2] == ST_FADE_IN) || (state_q[2*k +: 2] == ST_FADE_OUT);
      if (sample_tick_i) begin
        case (state_q[2*k +: 2])
          ST_OFF:  if (en)  g_nxt = g_cur + 1'b1;
          ST_ON:   if (!en) g_nxt = g_cur - 1'b1;
          default: g_nxt = en ? g_cur + 1'b1 : g_cur - 1'b1;
        endcase
        gain_d[k*GW +: GW] = g_nxt;
        if (g_nxt == '0)        state_d[2*k +: 2] = ST_OFF;
        else if (g_nxt == G_MAX) state_d[2*k +: 2] = ST_ON;
        else                    state_d[2*k +: 2] = en ? ST_FADE_IN : ST_FADE_OUT;
      end
    end
  end

  // Mix: y = (ret*g + send*(F-g)) >>> log2(F). Full-width signed products;
  // the result is a convex combination so it always fits DATA_WIDTH.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] send_k, ret_k;
    logic signed [PW-1:0]  send_ext, ret_ext, g_ext, gi_ext, acc;
    if (k == 0) begin : g_first
      assign send_k = data_i;
    end else begin : g_rest
      assign send_k = y_q[(k-1)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign ret_k    = return_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign send_ext = {{(PW-DATA_WIDTH){send_k[DATA_WIDTH-1]}}, send_k};
    assign ret_ext  = {{(PW-DATA_WIDTH){ret_k[DATA_WIDTH-1]}}, ret_k};
    assign g_ext    = {{(PW-GW){1'b0}}, gain_q[k*GW +: GW]};
    assign gi_ext   = {{(PW-GW){1'b0}}, G_MAX - gain_q[k*GW +: GW]};
    assign acc      = ret_ext * g_ext + send_ext * gi_ext;
    assign y_d[k*DATA_WIDTH +: DATA_WIDTH] =
      sample_tick_i ? DATA_WIDTH'(acc >>> FW) : y_q[k*DATA_WIDTH +: DATA_WIDTH];
    assign send_o[k*DATA_WIDTH +: DATA_WIDTH] = send_k;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      cnt_q    <= '0;
      map_q    <= DEFAULT_MAP;
      enable_q <= '0;
      gain_q   <= '0;
      state_q  <= {NUM_SLOTS{ST_OFF}};
      y_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
      map_q    <= map_d;
      enable_q <= enable_d;
      gain_q   <= gain_d;
      state_q  <= state_d;
      y_q      <= y_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign data_o              = y_q[(NUM_SLOTS-1)*DATA_WIDTH +: DATA_WIDTH];
  assign slot_active_o       = enable_q;
  assign slot_fading_o       = fading;
  assign csr_readdata_o      = rdata_q;
  assign csr_readdatavalid_o = rvalid_q;
  assign csr_waitrequest_o   = 1'b0;

endmodule
